// File: rtl/mult_div_seq_if.sv
// Operand/result bundle for the sequential signed multiply/divide unit.
// The master drives the request; the slave (the unit) returns results and status.
interface mult_div_seq_if #(
    parameter int WIDTH = 32
);
    // start is a request level, sampled only while the unit is idle;
    // done and Div0 are single-cycle pulses, and busy stays high from the
    // accepting edge to the edge that raises done.
    logic             start;
    logic             MultOrDiv;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             Div0;

    modport master (
        output start, MultOrDiv, A, B,
        input  HI, LO, busy, done, Div0
    );

    modport slave (
        input  start, MultOrDiv, A, B,
        output HI, LO, busy, done, Div0
    );
endinterface

// File: rtl/mult_div_seq.sv
// Sequential signed multiply (radix-2 Booth) and restoring divide, one step per cycle.
// HI/LO hold the last result and change only when an operation finishes.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    mult_div_seq_if.slave       bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             div0_flag_q, div0_flag_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            low_q       <= '0;
            qm1_q       <= 1'b0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            op_div_q    <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            div0_flag_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            low_q       <= low_d;
            qm1_q       <= qm1_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            op_div_q    <= op_div_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            div0_flag_q <= div0_flag_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div0_q      <= div0_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        low_d       = low_q;
        qm1_d       = qm1_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        op_div_d    = op_div_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        div0_flag_d = div0_flag_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div0_d      = 1'b0;
        booth_sum   = '0;
        trial       = '0;
        diff        = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d      = 1'b1;
                    op_div_d    = bus.MultOrDiv;
                    a_neg_d     = bus.A[WIDTH-1];
                    b_neg_d     = bus.B[WIDTH-1];
                    cnt_d       = '0;
                    acc_d       = '0;
                    qm1_d       = 1'b0;
                    div0_flag_d = 1'b0;
                    if (!bus.MultOrDiv) begin
                        state_d = MULT;
                        low_d   = bus.A;
                        mcand_d = bus.B;
                    end else if (bus.B == '0) begin
                        state_d     = FINISH;
                        div0_flag_d = 1'b1;
                        low_d       = '0;
                        mcand_d     = '0;
                    end else begin
                        // Divide works on magnitudes; the most negative value maps to itself as unsigned.
                        state_d = DIV;
                        low_d   = bus.A[WIDTH-1] ? -bus.A : bus.A;
                        mcand_d = bus.B[WIDTH-1] ? -bus.B : bus.B;
                    end
                end
            end

            MULT: begin
                booth_sum = acc_q;
                case ({low_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + {mcand_q[WIDTH-1], mcand_q};
                    2'b10:   booth_sum = acc_q - {mcand_q[WIDTH-1], mcand_q};
                    default: booth_sum = acc_q;
                endcase
                // acc carries one guard bit so that subtracting the most negative multiplicand cannot overflow.
                {acc_d, low_d, qm1_d} = {booth_sum[WIDTH], booth_sum, low_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end

            DIV: begin
                trial = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
                diff  = {1'b0, trial} - {2'b00, mcand_q};
                if (!diff[WIDTH+1]) begin
                    acc_d = diff[WIDTH:0];
                    low_d = {low_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = trial;
                    low_d = {low_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                div0_d  = div0_flag_q;
                if (!div0_flag_q) begin
                    if (op_div_q) begin
                        lo_d = (a_neg_q ^ b_neg_q) ? -low_q : low_q;
                        hi_d = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end else begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = low_q;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Div0 = div0_q;
    assign dbg_state = state_q;
endmodule
